// File: rtl/sandbox_command_engine_pkg.sv
// -----------------------------------------------------------------------------
// sandbox_command_engine_pkg
// Shared definitions for the sandbox command engine:
//   - command opcodes carried in the UART control byte
//   - FSM state encoding
//   - error signature placed in the upper half of an error response
//   - ALU result bundle and the error-response helper
// Optional feature macro: SANDBOX_CMD_COUNT_EN (adds OP_STATUS handling).
// -----------------------------------------------------------------------------
package sandbox_command_engine_pkg;

    localparam logic [7:0] OP_ECHO   = 8'h01;
    localparam logic [7:0] OP_ADD    = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_CLEAR  = 8'h04;
    localparam logic [7:0] OP_XOR    = 8'h05;
    localparam logic [7:0] OP_STATUS = 8'h06;

    localparam logic [15:0] ERR_SIG = 16'hDEAD;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACK      = 3'd1,
        EXEC     = 3'd2,
        TX_REQ   = 3'd3,
        TX_START = 3'd4,
        TX_BUSY  = 3'd5
    } state_t;

    // Result of one EXEC step. err sets the sticky error flag, clr clears it.
    typedef struct packed {
        logic [31:0] resp;
        logic [31:0] acc_next;
        logic        err;
        logic        clr;
    } alu_res_t;

    // Response word returned for an opcode the engine does not recognise.
    function automatic logic [31:0] err_word(input logic [7:0] op);
        return {ERR_SIG, 8'h00, op};
    endfunction

endpackage

// File: rtl/sandbox_cmd_alu.sv
// -----------------------------------------------------------------------------
// sandbox_cmd_alu
// Purely combinational opcode decoder/executor used during the EXEC cycle.
// Ports:
//   opcode     in   latched command byte
//   acc        in   current 32-bit accumulator
//   payload    in   latched payload (DATA_BITS wide, used as 32-bit operand)
//   err_flag   in   current sticky error  (SANDBOX_CMD_COUNT_EN only)
//   count_next in   command count including this one (SANDBOX_CMD_COUNT_EN only)
//   res        out  {resp, acc_next, err, clr}
// Optional feature macro: SANDBOX_CMD_COUNT_EN. Without it OP_STATUS falls
// through to the unknown-opcode path.
// -----------------------------------------------------------------------------
module sandbox_cmd_alu
    import sandbox_command_engine_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic [7:0]           opcode,
    input  logic [31:0]          acc,
    input  logic [DATA_BITS-1:0] payload,
`ifdef SANDBOX_CMD_COUNT_EN
    input  logic                 err_flag,
    input  logic [15:0]          count_next,
`endif
    output alu_res_t             res
);

    // The accumulator is fixed at 32 bits whatever the frame width is;
    // narrower payloads zero-extend, wider ones contribute their low word.
    logic [31:0] operand;
    assign operand = 32'(payload);

    always_comb begin
        res.resp     = '0;
        res.acc_next = acc;
        res.err      = 1'b0;
        res.clr      = 1'b0;
        case (opcode)
            OP_ECHO: begin
                res.resp = operand;
            end
            OP_ADD: begin
                res.acc_next = acc + operand;
                res.resp     = acc + operand;
            end
            OP_READ: begin
                res.resp = acc;
            end
            OP_CLEAR: begin
                res.acc_next = '0;
                res.resp     = '0;
                res.clr      = 1'b1;
            end
            OP_XOR: begin
                res.acc_next = acc ^ operand;
                res.resp     = acc ^ operand;
            end
`ifdef SANDBOX_CMD_COUNT_EN
            OP_STATUS: begin
                res.resp = {err_flag, 15'b0, count_next};
            end
`endif
            default: begin
                res.resp = err_word(opcode);
                res.err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sandbox_command_engine.sv
// -----------------------------------------------------------------------------
// sandbox_command_engine
// Sits between the wide UART receiver and transmitter. Each held frame is
// acknowledged with a single clearDR pulse, executed against a 32-bit
// accumulator, and answered with exactly one response word.
// Ports:
//   masterClock   in   clock, rising edge
//   reset         in   synchronous active-high reset
//   dataReceived  in   frame held by the UART (level)
//   control       in   opcode of the held frame
//   inputData     in   payload of the held frame
//   transmitting  in   UART is shifting a response out
//   clearDR       out  one-cycle acknowledge of the held frame
//   transmit      out  one-cycle request to send outputData
//   outputData    out  response word, held until the next EXEC
//   rxIndicator   out  toggles per accepted command
//   error         out  sticky: unknown opcode or TX timeout; cleared by CLEAR
// Optional feature macro: SANDBOX_CMD_COUNT_EN adds a 16-bit accepted-command
// counter and the STATUS opcode.
// -----------------------------------------------------------------------------
module sandbox_command_engine
    import sandbox_command_engine_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TX_TIMEOUT = 1024,
    localparam int DATA_BITS = 8 * WIDTH
) (
    input  logic                 masterClock,
    input  logic                 reset,
    input  logic                 dataReceived,
    input  logic [7:0]           control,
    input  logic [DATA_BITS-1:0] inputData,
    input  logic                 transmitting,
    output logic                 clearDR,
    output logic                 transmit,
    output logic [DATA_BITS-1:0] outputData,
    output logic                 rxIndicator,
    output logic                 error
);

    // Counter only needs to reach TX_TIMEOUT-1.
    localparam int CNT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

    state_t               state, state_next;
    logic [7:0]           op_q;
    logic [DATA_BITS-1:0] pay_q;
    logic [31:0]          acc;
    logic [CNT_W-1:0]     tx_cnt;
    alu_res_t             alu_res;

    logic accept;
    logic tx_expired;
    assign accept     = (state == IDLE) && dataReceived;
    assign tx_expired = (state == TX_START) && !transmitting && (tx_cnt == CNT_LAST);

`ifdef SANDBOX_CMD_COUNT_EN
    logic [15:0] cmd_count;
    logic [15:0] cmd_count_inc;
    assign cmd_count_inc = cmd_count + 16'd1;
`endif

    sandbox_cmd_alu #(
        .DATA_BITS (DATA_BITS)
    ) u_alu (
        .opcode     (op_q),
        .acc        (acc),
        .payload    (pay_q),
`ifdef SANDBOX_CMD_COUNT_EN
        .err_flag   (error),
        .count_next (cmd_count_inc),
`endif
        .res        (alu_res)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge masterClock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (dataReceived) state_next = ACK;
            // Wait for the UART to drop the frame so it cannot be re-accepted.
            ACK:      if (!dataReceived) state_next = EXEC;
            EXEC:     state_next = TX_REQ;
            TX_REQ:   state_next = TX_START;
            TX_START: begin
                if (transmitting)    state_next = TX_BUSY;
                else if (tx_expired) state_next = IDLE;
            end
            TX_BUSY:  if (!transmitting) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        transmit = (state == TX_REQ);
    end

    // ---------------- datapath ----------------
    // clearDR is registered off the accepting edge so it is high for the
    // first ACK cycle only, however long the UART takes to drop the frame.
    always_ff @(posedge masterClock) begin
        if (reset) begin
            clearDR     <= 1'b0;
            rxIndicator <= 1'b0;
            op_q        <= '0;
            pay_q       <= '0;
            acc         <= '0;
            outputData  <= '0;
            error       <= 1'b0;
            tx_cnt      <= '0;
        end else begin
            clearDR <= accept;

            if (accept) begin
                op_q        <= control;
                pay_q       <= inputData;
                rxIndicator <= ~rxIndicator;
            end

            if (state == EXEC) begin
                acc        <= alu_res.acc_next;
                outputData <= DATA_BITS'(alu_res.resp);
            end

            if (state == EXEC && alu_res.clr)      error <= 1'b0;
            else if (state == EXEC && alu_res.err) error <= 1'b1;
            else if (tx_expired)                   error <= 1'b1;

            if (state == TX_REQ)        tx_cnt <= '0;
            else if (state == TX_START) tx_cnt <= tx_cnt + 1'b1;
        end
    end

`ifdef SANDBOX_CMD_COUNT_EN
    always_ff @(posedge masterClock) begin
        if (reset)
            cmd_count <= '0;
        else if (state == EXEC)
            cmd_count <= (op_q == OP_CLEAR) ? 16'd0 : cmd_count_inc;
    end
`endif

endmodule

// File: tb/tb_sandbox_command_engine.sv
// -----------------------------------------------------------------------------
// Directed bench for sandbox_command_engine. The UART is modelled by hand:
// frames are presented on negedges, dropped one cycle after clearDR, and the
// transmitter is answered (or deliberately left silent) per step.
// -----------------------------------------------------------------------------
module tb_sandbox_command_engine;

    localparam int TXT = 16;

    logic        masterClock = 1'b0;
    logic        reset = 1'b1;
    logic        dataReceived = 1'b0;
    logic [7:0]  control = 8'h00;
    logic [31:0] inputData = 32'h0;
    logic        transmitting = 1'b0;
    logic        clearDR, transmit, rxIndicator, error;
    logic [31:0] outputData;

    int   checks = 0;
    int   failures = 0;
    logic rx_exp = 1'b0;

    always #5 masterClock = ~masterClock;

    sandbox_command_engine #(
        .WIDTH      (4),
        .TX_TIMEOUT (TXT)
    ) dut (
        .masterClock  (masterClock),
        .reset        (reset),
        .dataReceived (dataReceived),
        .control      (control),
        .inputData    (inputData),
        .transmitting (transmitting),
        .clearDR      (clearDR),
        .transmit     (transmit),
        .outputData   (outputData),
        .rxIndicator  (rxIndicator),
        .error        (error)
    );

    task automatic tick();
        @(negedge masterClock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a frame and follow it to the transmit pulse (ends in TX_REQ).
    task automatic send(input logic [7:0] op, input logic [31:0] pay,
                        input logic [31:0] exp, input string tag);
        int n;
        control      = op;
        inputData    = pay;
        dataReceived = 1'b1;
        n = 0;
        while (clearDR !== 1'b1 && n < 64) begin tick(); n++; end
        check({tag, ".clr"}, clearDR, 1);
        rx_exp = ~rx_exp;
        check({tag, ".rx"}, rxIndicator, rx_exp);
        tick();
        dataReceived = 1'b0;
        check({tag, ".clr_once"}, clearDR, 0);
        n = 0;
        while (transmit !== 1'b1 && n < 16) begin tick(); n++; end
        check({tag, ".lat"}, n, 2);
        check({tag, ".tx"}, transmit, 1);
        check({tag, ".data"}, outputData, exp);
    endtask

    // Play the UART transmitter: raise transmitting with the pulse, then drop.
    task automatic finish_tx(input logic [31:0] exp, input string tag);
        transmitting = 1'b1;
        tick();
        check({tag, ".tx_once"}, transmit, 0);
        tick();
        tick();
        check({tag, ".hold"}, outputData, exp);
        transmitting = 1'b0;
        tick();
        tick();
    endtask

    task automatic cmd(input logic [7:0] op, input logic [31:0] pay,
                       input logic [31:0] exp, input string tag);
        send(op, pay, exp, tag);
        finish_tx(exp, tag);
    endtask

    initial begin
        // ---- reset state ----
        reset = 1'b1;
        tick(); tick(); tick();
        check("rst.clearDR", clearDR, 0);
        check("rst.transmit", transmit, 0);
        check("rst.data", outputData, 0);
        check("rst.rx", rxIndicator, 0);
        check("rst.err", error, 0);
        reset = 1'b0;
        tick();

        // ---- echo ----
        cmd(8'h01, 32'h12345678, 32'h12345678, "echo");
        check("echo.rx_on", rxIndicator, 1);

        // ---- add with wrap, read back ----
        cmd(8'h02, 32'hFFFFFFF0, 32'hFFFFFFF0, "add1");
        cmd(8'h02, 32'h00000020, 32'h00000010, "add2");
        cmd(8'h03, 32'hDEADBEEF, 32'h00000010, "read1");
        cmd(8'h05, 32'h0000FF00, 32'h0000FF10, "xor");
        check("arith.err", error, 0);

        // ---- unknown opcode, then clear ----
        cmd(8'h7F, 32'h0, 32'hDEAD007F, "unk");
        check("unk.err", error, 1);
        cmd(8'h04, 32'h11111111, 32'h0, "clear");
        check("clear.err", error, 0);
        cmd(8'h03, 32'h0, 32'h0, "read2");

        // ---- tx timeout: transmitter never responds ----
        send(8'h01, 32'hA5A5A5A5, 32'hA5A5A5A5, "to");
        repeat (TXT) tick();
        check("to.err_early", error, 0);
        tick();
        check("to.err_set", error, 1);
        check("to.no_tx", transmit, 0);
        cmd(8'h01, 32'hCAFEF00D, 32'hCAFEF00D, "to_next");
        check("to.sticky", error, 1);
        cmd(8'h04, 32'h0, 32'h0, "clear2");
        check("clear2.err", error, 0);

        // ---- back-to-back: second frame arrives while transmitting ----
        send(8'h01, 32'h11111111, 32'h11111111, "b2b_a");
        transmitting = 1'b1;
        tick();
        tick();
        control      = 8'h01;
        inputData    = 32'h22222222;
        dataReceived = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b.hold_clr", clearDR, 0);
        end
        check("b2b.a_data", outputData, 32'h11111111);
        transmitting = 1'b0;
        tick();
        check("b2b.idle_clr", clearDR, 0);
        cmd(8'h01, 32'h22222222, 32'h22222222, "b2b_b");

        // ---- reset in the middle of TX_BUSY ----
        cmd(8'h02, 32'h00000005, 32'h00000005, "pre_add");
        send(8'h7F, 32'h0, 32'hDEAD007F, "pre_unk");
        transmitting = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid.clearDR", clearDR, 0);
        check("mid.transmit", transmit, 0);
        check("mid.data", outputData, 0);
        check("mid.rx", rxIndicator, 0);
        check("mid.err", error, 0);
        rx_exp       = 1'b0;
        reset        = 1'b0;
        transmitting = 1'b0;
        tick();
        cmd(8'h03, 32'h0, 32'h0, "mid.read");

        // ---- status opcode ----
        cmd(8'h01, 32'h1, 32'h1, "st1");
        cmd(8'h01, 32'h2, 32'h2, "st2");
`ifdef SANDBOX_CMD_COUNT_EN
        cmd(8'h06, 32'h0, 32'h00000004, "status");
        check("status.err", error, 0);
`else
        cmd(8'h06, 32'h0, 32'hDEAD0006, "status");
        check("status.err", error, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
